mcp3002_follower: RTL and testbench

- SPI follower that emulates the MCP3002 2-channel 10-bit ADC at its serial pins.
- Pairs with the team's ADC leader for closed-loop simulation and FPGA self-test, with no physical ADC required.
- Parallel channel values are supplied by a stimulus source (counter, ROM or NCO).
- Decodes the leader's config word (start, SGL/DIFF, ODD/SIGN, MSBF), captures the selected channel and serializes it on Dout.

---
 rtl/mcp3002_follower.sv | 254 +++++++++++++++++++++++++
 tb/tb_mcp3002_follower.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mcp3002_follower.sv
// -----------------------------------------------------------------------------
// mcp3002_follower
//
// Purpose:
//   SPI follower that behaves like an MCP3002 2-channel 10-bit ADC at its
//   serial pins. The leader clocks in a config word (start, SGL/DIFF,
//   ODD/SIGN, MSBF). The follower captures the selected channel, or a
//   pseudo-differential result clamped at zero, and shifts it out on Dout
//   as a null bit followed by the sample, MSB first.
//
// Configuration:
//   MCP3002_LSBF_EN  When defined, a frame with msbf=0 appends an LSB-first
//                    tail (B1..B[DATA_WIDTH-1]) after B0. When undefined,
//                    msbf is ignored and every frame is MSB-first only.
//
// Ports:
//   CLKsample    in   SPI clock. State and Din are sampled on rising edges.
//                     Dout is updated on falling edges.
//   RESET        in   Asynchronous active-low reset for both edge domains.
//   CS           in   Chip select, active-low. High at a rising edge aborts
//                     the frame.
//   Din          in   Serial config bits from the leader.
//   ch0_data     in   CH0 value, DATA_WIDTH bits.
//   ch1_data     in   CH1 value, DATA_WIDTH bits.
//   Dout         out  Serial sample to the leader.
//   Dout_oe      out  Pad output enable. High while a frame is driving Dout.
//   sample_held  out  Value captured for the current or last frame.
//   frame_done   out  One-cycle pulse after the last data bit was driven.
// -----------------------------------------------------------------------------
module mcp3002_follower #(
  parameter int   DATA_WIDTH = 10,
  parameter logic IDLE_DOUT  = 1'b0
) (
  input  logic                  CLKsample,
  input  logic                  RESET,
  input  logic                  CS,
  input  logic                  Din,
  input  logic [DATA_WIDTH-1:0] ch0_data,
  input  logic [DATA_WIDTH-1:0] ch1_data,
  output logic                  Dout,
  output logic                  Dout_oe,
  output logic [DATA_WIDTH-1:0] sample_held,
  output logic                  frame_done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH);
`ifdef MCP3002_LSBF_EN
  localparam logic [CW-1:0] CNT_TAIL_LAST = CW'(DATA_WIDTH - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    CFG_SGL,
    CFG_ODD,
    CFG_MSBF,
    SHIFT_MSB,
    SHIFT_LSB,
    DONE
  } state_t;

  // Rising-edge domain
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sgl_q, sgl_d;
  logic                    odd_q, odd_d;
  logic [DATA_WIDTH-1:0]   held_q, held_d;
  logic                    done_q, done_d;
`ifdef MCP3002_LSBF_EN
  logic                    msbf_q, msbf_d;
`endif

  // Falling-edge domain
  logic                    dout_q, dout_d;
  logic                    oe_q, oe_d;

  // Capture selection. Differential results clamp at zero rather than wrap.
  logic [DATA_WIDTH-1:0]   diff_01, diff_10, capture;

  assign diff_01 = (ch0_data >= ch1_data) ? (ch0_data - ch1_data) : '0;
  assign diff_10 = (ch1_data >= ch0_data) ? (ch1_data - ch0_data) : '0;

  always_comb begin
    capture = '0;
    case ({sgl_q, odd_q})
      2'b10:   capture = ch0_data;
      2'b11:   capture = ch1_data;
      2'b00:   capture = diff_01;
      default: capture = diff_10;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Rising-edge FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLKsample or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sgl_q   <= 1'b0;
      odd_q   <= 1'b0;
      held_q  <= '0;
      done_q  <= 1'b0;
`ifdef MCP3002_LSBF_EN
      msbf_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgl_q   <= sgl_d;
      odd_q   <= odd_d;
      held_q  <= held_d;
      done_q  <= done_d;
`ifdef MCP3002_LSBF_EN
      msbf_q  <= msbf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgl_d   = sgl_q;
    odd_d   = odd_q;
    held_d  = held_q;
    done_d  = 1'b0;
`ifdef MCP3002_LSBF_EN
    msbf_d  = msbf_q;
`endif

    if (CS) begin
      // Deselect wins everywhere. An abort never raises frame_done, and
      // the held sample is left untouched.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Leading zeros before the start bit are ignored.
          if (Din) state_d = CFG_SGL;
        end
        CFG_SGL: begin
          sgl_d   = Din;
          state_d = CFG_ODD;
        end
        CFG_ODD: begin
          odd_d   = Din;
          state_d = CFG_MSBF;
        end
        CFG_MSBF: begin
`ifdef MCP3002_LSBF_EN
          msbf_d  = Din;
`endif
          held_d  = capture;
          cnt_d   = '0;
          state_d = SHIFT_MSB;
        end
        SHIFT_MSB: begin
          // cnt_q=0 is the null-bit slot. cnt_q=k drives B[DATA_WIDTH-k].
          // Leave once the leader has sampled B0.
          if (cnt_q == CNT_LAST) begin
`ifdef MCP3002_LSBF_EN
            if (!msbf_q) begin
              state_d = SHIFT_LSB;
              cnt_d   = CW'(1);
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
              cnt_d   = '0;
            end
`else
            state_d = DONE;
            done_d  = 1'b1;
            cnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SHIFT_LSB: begin
`ifdef MCP3002_LSBF_EN
          // cnt_q=k drives B[k]. The tail ends after B[DATA_WIDTH-1].
          if (cnt_q == CNT_TAIL_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          state_d = IDLE;
          cnt_d   = '0;
`endif
        end
        DONE: begin
          // Stay here until CS rises. Din is ignored.
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Falling-edge output stage
  // ---------------------------------------------------------------------------
  always_comb begin
    dout_d = IDLE_DOUT;
    oe_d   = 1'b0;
    case (state_q)
      SHIFT_MSB: begin
        oe_d = 1'b1;
        if (cnt_q == '0) dout_d = 1'b0;
        else             dout_d = held_q[CNT_LAST - cnt_q];
      end
`ifdef MCP3002_LSBF_EN
      SHIFT_LSB: begin
        oe_d   = 1'b1;
        dout_d = held_q[cnt_q];
      end
`endif
      DONE: begin
        oe_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(negedge CLKsample or negedge RESET) begin
    if (!RESET) begin
      dout_q <= IDLE_DOUT;
      oe_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      oe_q   <= oe_d;
    end
  end

  // The falling-edge enable is qualified by the rising-edge state.
  // Deselect therefore drops Dout_oe on the same rising edge that aborts
  // the frame, instead of half a cycle later.
  logic frame_active;
  assign frame_active = (state_q == SHIFT_MSB) || (state_q == SHIFT_LSB) ||
                        (state_q == DONE);

  assign Dout_oe     = oe_q && frame_active;
  assign Dout        = Dout_oe ? dout_q : IDLE_DOUT;
  assign sample_held = held_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_mcp3002_follower.sv
// -----------------------------------------------------------------------------
// tb_mcp3002_follower
//
// Directed testbench for mcp3002_follower with DATA_WIDTH=10 and
// IDLE_DOUT=0. Inputs change 1 time unit after each rising edge. Outputs
// are sampled at the same point, which is away from both clock edges.
// Expected values are hand-derived from the MCP3002 frame timing.
// Compile with MCP3002_LSBF_EN to cover the LSB-first tail.
// -----------------------------------------------------------------------------
module tb_mcp3002_follower;

  logic       CLKsample;
  logic       RESET;
  logic       CS;
  logic       Din;
  logic [9:0] ch0_data;
  logic [9:0] ch1_data;
  logic       Dout;
  logic       Dout_oe;
  logic [9:0] sample_held;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  mcp3002_follower #(
    .DATA_WIDTH (10),
    .IDLE_DOUT  (1'b0)
  ) dut (
    .CLKsample   (CLKsample),
    .RESET       (RESET),
    .CS          (CS),
    .Din         (Din),
    .ch0_data    (ch0_data),
    .ch1_data    (ch1_data),
    .Dout        (Dout),
    .Dout_oe     (Dout_oe),
    .sample_held (sample_held),
    .frame_done  (frame_done)
  );

  initial CLKsample = 1'b0;
  always #5 CLKsample = ~CLKsample;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one Din bit for the next rising edge, then settle 1 unit past it.
  task automatic step(input logic b);
    Din = b;
    @(posedge CLKsample);
    #1;
  endtask

  // Full frame: nlead zeros, start bit, then {sgl, odd, msbf}.
  task automatic do_frame(input int nlead, input logic [2:0] cfg,
                          input logic [9:0] expv, input logic zap_ch0,
                          input string tag);
    logic tail;
    tail = 1'b0;
`ifdef MCP3002_LSBF_EN
    tail = ~cfg[0];
`endif
    CS = 1'b0;
    for (int i = 0; i < nlead; i++) begin
      step(1'b0);
      chk({tag, "_lead_oe"}, 32'(Dout_oe), 32'd0);
    end
    step(1'b1);       // Rk: start bit
    step(cfg[2]);     // Rk+1: sgl
    step(cfg[1]);     // Rk+2: odd
    step(cfg[0]);     // Rk+3: msbf and capture
    chk({tag, "_held"}, 32'(sample_held), 32'(expv));
    chk({tag, "_oe_pre"}, 32'(Dout_oe), 32'd0);
    if (zap_ch0) ch0_data = 10'd0;
    step(1'b0);       // Rk+4: null bit from Fk+3 is visible
    chk({tag, "_null_oe"}, 32'(Dout_oe), 32'd1);
    chk({tag, "_null_dout"}, 32'(Dout), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0);     // Rk+5+i: leader samples B[9-i]
      chk({tag, "_msb_bit"}, 32'(Dout), 32'(expv[9-i]));
      chk({tag, "_msb_fd"}, 32'(frame_done), 32'((i == 9) && !tail));
    end
    if (tail) begin
      for (int i = 1; i < 10; i++) begin
        step(1'b0);
        chk({tag, "_lsb_bit"}, 32'(Dout), 32'(expv[i]));
        chk({tag, "_lsb_fd"}, 32'(frame_done), 32'(i == 9));
      end
    end
    step(1'b1);       // DONE: Din ignored, Dout idles with oe held
    chk({tag, "_done_dout"}, 32'(Dout), 32'd0);
    chk({tag, "_done_oe"}, 32'(Dout_oe), 32'd1);
    chk({tag, "_done_fd"}, 32'(frame_done), 32'd0);
    CS = 1'b1;
    step(1'b0);
    chk({tag, "_desel_oe"}, 32'(Dout_oe), 32'd0);
    $display("frame %s cfg=%b expected=%h held=%h", tag, cfg, expv, sample_held);
  endtask

  initial begin
    RESET    = 1'b0;
    CS       = 1'b1;
    Din      = 1'b0;
    ch0_data = 10'd0;
    ch1_data = 10'd0;
    repeat (2) @(posedge CLKsample);
    #1;
    chk("rst_dout", 32'(Dout), 32'd0);
    chk("rst_oe", 32'(Dout_oe), 32'd0);
    chk("rst_held", 32'(sample_held), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    RESET = 1'b1;
    step(1'b0);
    chk("idle_oe", 32'(Dout_oe), 32'd0);

    // Single-ended CH1, MSB first
    ch0_data = 10'h123;
    ch1_data = 10'h2A5;
    do_frame(0, 3'b111, 10'h2A5, 1'b0, "se_ch1");

    // Pseudo-differential: 700-200=500. Reversed polarity clamps to 0.
    ch0_data = 10'd700;
    ch1_data = 10'd200;
    do_frame(0, 3'b001, 10'd500, 1'b0, "diff_01");
    do_frame(0, 3'b011, 10'd0, 1'b0, "diff_10_sat");

    // Leading zeros; ch0 is cleared after capture
    ch0_data = 10'h3FF;
    do_frame(3, 3'b101, 10'h3FF, 1'b1, "lead_zap");

    // Abort after B5 has been driven
    ch0_data = 10'h155;
    CS = 1'b0;
    step(1'b1); step(1'b1); step(1'b0); step(1'b1);
    chk("abort_held", 32'(sample_held), 32'h155);
    step(1'b0);
    chk("abort_null_oe", 32'(Dout_oe), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      chk("abort_bit", 32'(Dout), 32'(((10'h155) >> (9 - i)) & 10'h1));
    end
    CS = 1'b1;
    step(1'b0);
    chk("abort_oe", 32'(Dout_oe), 32'd0);
    chk("abort_fd", 32'(frame_done), 32'd0);
    step(1'b0);
    chk("abort_fd2", 32'(frame_done), 32'd0);
    chk("abort_held_kept", 32'(sample_held), 32'h155);
    $display("abort frame held=%h", sample_held);

    // CS low for too few edges: no capture
    ch0_data = 10'h0AA;
    CS = 1'b0;
    step(1'b1); step(1'b1);
    CS = 1'b1;
    step(1'b1);
    chk("short_held", 32'(sample_held), 32'h155);
    chk("short_oe", 32'(Dout_oe), 32'd0);
    $display("short frame held=%h", sample_held);

    // A normal frame decodes after the abort
    ch0_data = 10'h0F0;
    do_frame(0, 3'b101, 10'h0F0, 1'b0, "post_abort");

    // msbf=0: LSB-first tail when enabled, otherwise MSB-first only
    ch1_data = 10'h2A5;
    do_frame(0, 3'b110, 10'h2A5, 1'b0, "msbf0");

    // Asynchronous reset in the middle of SHIFT_MSB
    ch1_data = 10'h3C3;
    CS = 1'b0;
    step(1'b1); step(1'b1); step(1'b1); step(1'b1);
    chk("arst_held_pre", 32'(sample_held), 32'h3C3);
    step(1'b0); step(1'b0); step(1'b0);
    chk("arst_oe_pre", 32'(Dout_oe), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_oe", 32'(Dout_oe), 32'd0);
    chk("arst_dout", 32'(Dout), 32'd0);
    chk("arst_held", 32'(sample_held), 32'd0);
    chk("arst_fd", 32'(frame_done), 32'd0);
    @(posedge CLKsample);
    #1;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("arst_noframe_oe", 32'(Dout_oe), 32'd0);
    end
    $display("async reset mid-frame held=%h", sample_held);
    do_frame(0, 3'b111, 10'h3C3, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
